// File: rtl/dh_pkg.sv
// Shared widths, FSM states and link-parameter record for the DH host driver.
package dh_pkg;

  localparam int unsigned ANG_W     = 6;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned POS_W     = 9;
  localparam int unsigned NUM_LINKS = 4;
  localparam int unsigned IDX_W     = $clog2(NUM_LINKS);

  typedef enum logic [2:0] {
    IDLE,
    LINK,
    GAP,
    THETA,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic signed [ANG_W-1:0] alpha;
    logic [LEN_W-1:0]        a;
    logic [LEN_W-1:0]        d;
  } dh_link_t;

endpackage

// File: rtl/dh_host_driver_if.sv
// Input/output bus of the DH forward-kinematics core as seen by its initiator.
interface dh_host_driver_if;
  import dh_pkg::*;

  logic                    IN_VALID_1;
  logic                    IN_VALID_2;
  logic signed [ANG_W-1:0] ALPHA_I;
  logic [LEN_W-1:0]        A_I;
  logic [LEN_W-1:0]        D_I;
  logic signed [ANG_W-1:0] THETA_JOINT_1;
  logic signed [ANG_W-1:0] THETA_JOINT_2;
  logic signed [ANG_W-1:0] THETA_JOINT_3;
  logic signed [ANG_W-1:0] THETA_JOINT_4;
  logic                    OUT_VALID;
  logic signed [POS_W-1:0] OUT_X;
  logic signed [POS_W-1:0] OUT_Y;
  logic signed [POS_W-1:0] OUT_Z;

  modport master (
    output IN_VALID_1, IN_VALID_2, ALPHA_I, A_I, D_I,
    output THETA_JOINT_1, THETA_JOINT_2, THETA_JOINT_3, THETA_JOINT_4,
    input  OUT_VALID, OUT_X, OUT_Y, OUT_Z
  );

  modport slave (
    input  IN_VALID_1, IN_VALID_2, ALPHA_I, A_I, D_I,
    input  THETA_JOINT_1, THETA_JOINT_2, THETA_JOINT_3, THETA_JOINT_4,
    output OUT_VALID, OUT_X, OUT_Y, OUT_Z
  );

endinterface

// File: rtl/dh_link_table.sv
// Link-parameter register file: one synchronous write port, one combinational read port.
module dh_link_table
  import dh_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  dh_link_t         wdata,
  input  logic [IDX_W-1:0] raddr,
  output dh_link_t         rdata_c
);

  dh_link_t entries [NUM_LINKS];

  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '{default: '0};
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  assign rdata_c = entries[raddr];

endmodule

// File: rtl/dh_host_driver.sv
// Host-side initiator for the DH core: replays the link table and latched joint
// angles for each pose, then returns the core result (or a timeout) to the host.
module dh_host_driver
  import dh_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lt_we,
  input  logic [IDX_W-1:0]        lt_addr,
  input  logic signed [ANG_W-1:0] lt_alpha,
  input  logic [LEN_W-1:0]        lt_a,
  input  logic [LEN_W-1:0]        lt_d,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [ANG_W-1:0] cmd_theta1,
  input  logic signed [ANG_W-1:0] cmd_theta2,
  input  logic signed [ANG_W-1:0] cmd_theta3,
  input  logic signed [ANG_W-1:0] cmd_theta4,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [POS_W-1:0] res_x,
  output logic signed [POS_W-1:0] res_y,
  output logic signed [POS_W-1:0] res_z,
  output logic                    res_timeout,
  output logic                    busy,
  output logic                    err_spurious,
  dh_host_driver_if.master        core
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ANG_W-1:0] theta_q [NUM_LINKS];
  logic signed [ANG_W-1:0] theta_d [NUM_LINKS];
  logic signed [ANG_W-1:0] cmd_theta [NUM_LINKS];
  logic signed [POS_W-1:0] res_x_d, res_y_d, res_z_d;
  logic                    res_timeout_d;
  logic                    err_d;

  logic                    iv1_q, iv1_d;
  logic                    iv2_q, iv2_d;
  logic signed [ANG_W-1:0] alpha_q, alpha_d;
  logic [LEN_W-1:0]        a_q, a_d;
  logic [LEN_W-1:0]        d_q, d_d;
  logic signed [ANG_W-1:0] th_q [NUM_LINKS];
  logic signed [ANG_W-1:0] th_d [NUM_LINKS];

  logic                    lt_wr;
  dh_link_t                lt_wdata;
  dh_link_t                link_rd;
  dh_link_t                link_nxt;

  assign cmd_theta[0] = cmd_theta1;
  assign cmd_theta[1] = cmd_theta2;
  assign cmd_theta[2] = cmd_theta3;
  assign cmd_theta[3] = cmd_theta4;

  // Host writes are only honoured while no pose is in flight
  assign lt_wr    = lt_we && !busy;
  assign lt_wdata = '{alpha: lt_alpha, a: lt_a, d: lt_d};

  dh_link_table u_link_table (
    .clk     (clk),
    .rst     (rst),
    .we      (lt_wr),
    .waddr   (lt_addr),
    .wdata   (lt_wdata),
    .raddr   (idx_d),
    .rdata_c (link_rd)
  );

  // A write landing in the accept cycle is visible to the first link beat
  assign link_nxt = (lt_wr && (lt_addr == idx_d)) ? lt_wdata : link_rd;

  // Next-state, sequencing and result capture
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    theta_d       = theta_q;
    res_x_d       = res_x;
    res_y_d       = res_y;
    res_z_d       = res_z;
    res_timeout_d = res_timeout;
    err_d         = err_spurious || (core.OUT_VALID && (state_q != WAIT));

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = LINK;
          idx_d   = '0;
          theta_d = cmd_theta;
        end
      end
      LINK: begin
        if (idx_q == IDX_W'(NUM_LINKS - 1)) begin
          state_d = GAP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      GAP: begin
        state_d = THETA;
      end
      THETA: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // Data arriving on the final count still wins over the timeout
        if (core.OUT_VALID) begin
          state_d       = RESP;
          res_x_d       = core.OUT_X;
          res_y_d       = core.OUT_Y;
          res_z_d       = core.OUT_Z;
          res_timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = RESP;
          res_x_d       = '0;
          res_y_d       = '0;
          res_z_d       = '0;
          res_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Core-side beats are decoded from the next state so they register in step with it
  always_comb begin
    iv1_d   = (state_d == LINK);
    iv2_d   = (state_d == THETA);
    alpha_d = '0;
    a_d     = '0;
    d_d     = '0;
    th_d    = '{default: '0};
    if (iv1_d) begin
      alpha_d = link_nxt.alpha;
      a_d     = link_nxt.a;
      d_d     = link_nxt.d;
    end
    if (iv2_d) begin
      th_d = theta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      theta_q      <= '{default: '0};
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_x        <= '0;
      res_y        <= '0;
      res_z        <= '0;
      res_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      iv1_q        <= 1'b0;
      iv2_q        <= 1'b0;
      alpha_q      <= '0;
      a_q          <= '0;
      d_q          <= '0;
      th_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      theta_q      <= theta_d;
      cmd_ready    <= (state_d == IDLE);
      busy         <= (state_d != IDLE);
      res_valid    <= (state_d == RESP);
      res_x        <= res_x_d;
      res_y        <= res_y_d;
      res_z        <= res_z_d;
      res_timeout  <= res_timeout_d;
      err_spurious <= err_d;
      iv1_q        <= iv1_d;
      iv2_q        <= iv2_d;
      alpha_q      <= alpha_d;
      a_q          <= a_d;
      d_q          <= d_d;
      th_q         <= th_d;
    end
  end

  assign core.IN_VALID_1    = iv1_q;
  assign core.IN_VALID_2    = iv2_q;
  assign core.ALPHA_I       = alpha_q;
  assign core.A_I           = a_q;
  assign core.D_I           = d_q;
  assign core.THETA_JOINT_1 = th_q[0];
  assign core.THETA_JOINT_2 = th_q[1];
  assign core.THETA_JOINT_3 = th_q[2];
  assign core.THETA_JOINT_4 = th_q[3];

endmodule

// File: tb/tb_dh_host_driver.sv
// Scoreboard bench for dh_host_driver with a scripted DH core model.
module tb_dh_host_driver;
  import dh_pkg::*;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic       iv1;
    logic       iv2;
    logic [5:0] alpha;
    logic [2:0] a;
    logic [2:0] d;
    logic [5:0] t1;
    logic [5:0] t2;
    logic [5:0] t3;
    logic [5:0] t4;
  } beat_t;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] z;
    logic       to;
  } res_t;

  logic       clk, rst;
  logic       lt_we;
  logic [1:0] lt_addr;
  logic [5:0] lt_alpha;
  logic [2:0] lt_a, lt_d;
  logic       cmd_valid, cmd_ready;
  logic [5:0] cmd_theta1, cmd_theta2, cmd_theta3, cmd_theta4;
  logic       res_valid, res_ready;
  logic [8:0] res_x, res_y, res_z;
  logic       res_timeout, busy, err_spurious;

  dh_host_driver_if core_if ();

  dh_host_driver #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .lt_we        (lt_we),
    .lt_addr      (lt_addr),
    .lt_alpha     (lt_alpha),
    .lt_a         (lt_a),
    .lt_d         (lt_d),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_theta1   (cmd_theta1),
    .cmd_theta2   (cmd_theta2),
    .cmd_theta3   (cmd_theta3),
    .cmd_theta4   (cmd_theta4),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_z        (res_z),
    .res_timeout  (res_timeout),
    .busy         (busy),
    .err_spurious (err_spurious),
    .core         (core_if)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  beat_t beat_q [$];
  res_t  res_q  [$];
  logic [5:0] mdl_alpha [4];
  logic [2:0] mdl_a [4];
  logic [2:0] mdl_d [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  function automatic beat_t observe();
    beat_t b;
    b.iv1   = core_if.IN_VALID_1;
    b.iv2   = core_if.IN_VALID_2;
    b.alpha = core_if.ALPHA_I;
    b.a     = core_if.A_I;
    b.d     = core_if.D_I;
    b.t1    = core_if.THETA_JOINT_1;
    b.t2    = core_if.THETA_JOINT_2;
    b.t3    = core_if.THETA_JOINT_3;
    b.t4    = core_if.THETA_JOINT_4;
    return b;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      mdl_alpha[k] = '0;
      mdl_a[k]     = '0;
      mdl_d[k]     = '0;
    end
  endtask

  task automatic wr_link(input logic [1:0] idx, input logic [5:0] al,
                         input logic [2:0] a, input logic [2:0] d, input bit upd);
    lt_we = 1'b1; lt_addr = idx; lt_alpha = al; lt_a = a; lt_d = d;
    tick();
    lt_we = 1'b0;
    if (upd) begin
      mdl_alpha[idx] = al; mdl_a[idx] = a; mdl_d[idx] = d;
    end
  endtask

  // Cycle 0 of a pose: drive the command, queue the expected core beats
  task automatic start_pose(input logic [5:0] t1, input logic [5:0] t2,
                            input logic [5:0] t3, input logic [5:0] t4, output logic rdy);
    beat_t b;
    cmd_valid = 1'b1;
    cmd_theta1 = t1; cmd_theta2 = t2; cmd_theta3 = t3; cmd_theta4 = t4;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      b = '0; b.iv1 = 1'b1; b.alpha = mdl_alpha[k]; b.a = mdl_a[k]; b.d = mdl_d[k];
      beat_q.push_back(b);
    end
    b = '0;
    beat_q.push_back(b);
    b.iv2 = 1'b1; b.t1 = t1; b.t2 = t2; b.t3 = t3; b.t4 = t4;
    beat_q.push_back(b);
    @(negedge clk);
    rdy = cmd_ready;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic core_respond(input logic [8:0] x, input logic [8:0] y, input logic [8:0] z);
    core_if.OUT_VALID = 1'b1;
    core_if.OUT_X = x; core_if.OUT_Y = y; core_if.OUT_Z = z;
    res_q.push_back('{x: x, y: y, z: z, to: 1'b0});
    tick();
    core_if.OUT_VALID = 1'b0;
    core_if.OUT_X = '0; core_if.OUT_Y = '0; core_if.OUT_Z = '0;
  endtask

  task automatic handshake();
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({observe(), cmd_ready, busy, res_valid, res_x, res_y, res_z, res_timeout, err_spurious} !== '0)
      begin errors++; $display("FAIL reset_outputs got core=%h rdy=%b busy=%b rv=%b err=%b exp all 0",
                               observe(), cmd_ready, busy, res_valid, err_spurious); end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b10)
      begin errors++; $display("FAIL reset_release got rdy=%b busy=%b exp rdy=1 busy=0", cmd_ready, busy); end
  endtask

  task automatic test_link_phase();
    logic rdy;
    beat_t e, o;
    tick();
    wr_link(2'd0, 6'h05, 3'd1, 3'd2, 1'b1);
    wr_link(2'd1, 6'h3D, 3'd7, 3'd0, 1'b1);
    wr_link(2'd2, 6'h1F, 3'd4, 3'd4, 1'b1);
    wr_link(2'd3, 6'h20, 3'd0, 3'd7, 1'b1);
    start_pose(6'h01, 6'h3F, 6'h0A, 6'h2C, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL accept_ready got %b exp 1", rdy); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e = beat_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin errors++; $display("FAIL link_phase cyc=%0d got %h exp %h", cyc, o, e); end
      tick();
    end
  endtask

  task automatic test_result_hold();
    res_t e, o;
    bit seen = 0;
    run_to(20);
    core_respond(9'h064, 9'h100, 9'h0FF);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1; else tick();
    end
    checks++;
    if (!seen || cyc != 21) begin errors++; $display("FAIL result_latency got cyc=%0d seen=%0b exp cyc=21", cyc, seen); end
    e = res_q.pop_front();
    o = '{x: res_x, y: res_y, z: res_z, to: res_timeout};
    checks++;
    if (o !== e) begin errors++; $display("FAIL result_data got %h exp %h", o, e); end
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      o = '{x: res_x, y: res_y, z: res_z, to: res_timeout};
      checks++;
      if ({res_valid, cmd_ready, o} !== {1'b1, 1'b0, e})
        begin errors++; $display("FAIL result_hold cyc=%0d got rv=%b rdy=%b %h exp rv=1 rdy=0 %h",
                                 cyc, res_valid, cmd_ready, o, e); end
    end
    handshake();
    @(negedge clk);
    checks++;
    if ({res_valid, cmd_ready, busy} !== 3'b010)
      begin errors++; $display("FAIL after_handshake got rv=%b rdy=%b busy=%b exp 0 1 0", res_valid, cmd_ready, busy); end
  endtask

  task automatic test_timeout();
    logic rdy;
    res_t e, o;
    bit seen = 0;
    tick();
    start_pose(6'h02, 6'h03, 6'h04, 6'h05, rdy);
    beat_q.delete();
    res_q.push_back('{x: 9'h0, y: 9'h0, z: 9'h0, to: 1'b1});
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1; else tick();
    end
    checks++;
    if (!seen || cyc != 7 + int'(TO)) begin errors++; $display("FAIL timeout_latency got cyc=%0d seen=%0b exp cyc=%0d", cyc, seen, 7 + TO); end
    e = res_q.pop_front();
    o = '{x: res_x, y: res_y, z: res_z, to: res_timeout};
    checks++;
    if (o !== e) begin errors++; $display("FAIL timeout_data got %h exp %h", o, e); end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic rdy;
    res_t e, o;
    bit seen = 0;
    start_pose(6'h07, 6'h08, 6'h09, 6'h0A, rdy);
    beat_q.delete();
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_accept got rdy=%b exp 1", rdy); end
    run_to(6 + int'(TO));
    core_respond(9'h001, 9'h1FE, 9'h003);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1; else tick();
    end
    checks++;
    if (!seen || cyc != 7 + int'(TO)) begin errors++; $display("FAIL limit_latency got cyc=%0d exp %0d", cyc, 7 + TO); end
    e = res_q.pop_front();
    o = '{x: res_x, y: res_y, z: res_z, to: res_timeout};
    checks++;
    if (o !== e) begin errors++; $display("FAIL limit_data_wins got %h exp %h", o, e); end
    handshake();
  endtask

  task automatic test_write_while_busy();
    logic rdy;
    res_t e, o;
    beat_t eb, ob;
    bit seen = 0;
    tick();
    start_pose(6'h11, 6'h12, 6'h13, 6'h14, rdy);
    beat_q.delete();
    run_to(10);
    wr_link(2'd1, 6'h15, 3'd3, 3'd3, 1'b0);
    run_to(12);
    core_respond(9'h0AA, 9'h055, 9'h1FF);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1; else tick();
    end
    e = res_q.pop_front();
    o = '{x: res_x, y: res_y, z: res_z, to: res_timeout};
    checks++;
    if (!seen || cyc != 13 || o !== e)
      begin errors++; $display("FAIL busy_pose_result cyc=%0d got %h exp cyc=13 %h", cyc, o, e); end
    handshake();
    // Write to link 1 in the same cycle as the accept must reach the first beat
    tick();
    lt_we = 1'b1; lt_addr = 2'd0; lt_alpha = 6'h09; lt_a = 3'd2; lt_d = 3'd5;
    mdl_alpha[0] = 6'h09; mdl_a[0] = 3'd2; mdl_d[0] = 3'd5;
    start_pose(6'h21, 6'h22, 6'h23, 6'h24, rdy);
    lt_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      eb = beat_q.pop_front();
      ob = observe();
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL resend_table cyc=%0d got %h exp %h", cyc, ob, eb); end
      tick();
    end
    run_to(9);
    core_respond(9'h010, 9'h020, 9'h030);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1; else tick();
    end
    e = res_q.pop_front();
    o = '{x: res_x, y: res_y, z: res_z, to: res_timeout};
    checks++;
    if (!seen || cyc != 10 || o !== e)
      begin errors++; $display("FAIL short_latency cyc=%0d got %h exp cyc=10 %h", cyc, o, e); end
    handshake();
  endtask

  task automatic test_spurious();
    logic rdy;
    res_t e, o;
    bit seen = 0;
    tick();
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b0) begin errors++; $display("FAIL spurious_clear got %b exp 0", err_spurious); end
    tick();
    core_if.OUT_VALID = 1'b1; core_if.OUT_X = 9'h123;
    tick();
    core_if.OUT_VALID = 1'b0; core_if.OUT_X = '0;
    @(negedge clk);
    checks++;
    if ({err_spurious, res_valid, cmd_ready} !== 3'b101)
      begin errors++; $display("FAIL spurious_idle got err=%b rv=%b rdy=%b exp 1 0 1", err_spurious, res_valid, cmd_ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    tick();
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b0) begin errors++; $display("FAIL spurious_rst got %b exp 0", err_spurious); end
    tick();
    start_pose(6'h01, 6'h01, 6'h01, 6'h01, rdy);
    beat_q.delete();
    run_to(2);
    core_if.OUT_VALID = 1'b1; core_if.OUT_X = 9'h077;
    tick();
    core_if.OUT_VALID = 1'b0; core_if.OUT_X = '0;
    @(negedge clk);
    checks++;
    if ({err_spurious, res_valid, busy} !== 3'b101)
      begin errors++; $display("FAIL spurious_link got err=%b rv=%b busy=%b exp 1 0 1", err_spurious, res_valid, busy); end
    run_to(12);
    core_respond(9'h1FF, 9'h000, 9'h001);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1; else tick();
    end
    e = res_q.pop_front();
    o = '{x: res_x, y: res_y, z: res_z, to: res_timeout};
    checks++;
    if (!seen || cyc != 13 || o !== e)
      begin errors++; $display("FAIL spurious_pose_result cyc=%0d got %h exp cyc=13 %h", cyc, o, e); end
    handshake();
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin errors++; $display("FAIL spurious_sticky got %b exp 1", err_spurious); end
  endtask

  task automatic test_rst_mid_link();
    logic rdy;
    int   stray = 0;
    beat_t eb, ob;
    tick();
    start_pose(6'h05, 6'h06, 6'h07, 6'h08, rdy);
    beat_q.delete();
    run_to(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    checks++;
    if ({observe(), cmd_ready, busy, res_valid, res_x, res_y, res_z, res_timeout, err_spurious} !== '0)
      begin errors++; $display("FAIL rst_mid_link got core=%h rdy=%b busy=%b rv=%b err=%b exp all 0",
                               observe(), cmd_ready, busy, res_valid, err_spurious); end
    tick();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    for (int i = 0; i < 30; i++) begin
      tick();
      @(negedge clk);
      if (res_valid !== 1'b0 || core_if.IN_VALID_1 !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rst_dropped_pose got %0d active cycles exp 0", stray); end
    tick();
    start_pose(6'h31, 6'h32, 6'h33, 6'h34, rdy);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      eb = beat_q.pop_front();
      ob = observe();
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL cleared_table cyc=%0d got %h exp %h", cyc, ob, eb); end
      tick();
    end
    run_to(8);
    core_respond(9'h002, 9'h004, 9'h008);
    @(negedge clk);
    checks++;
    if ({res_valid, res_x, res_y, res_z, res_timeout} !== {1'b1, 9'h002, 9'h004, 9'h008, 1'b0})
      begin errors++; $display("FAIL post_rst_result got rv=%b %h %h %h to=%b exp 1 002 004 008 0",
                               res_valid, res_x, res_y, res_z, res_timeout); end
    void'(res_q.pop_front());
    handshake();
  endtask

  initial begin
    rst = 1'b1; lt_we = 1'b0; lt_addr = '0; lt_alpha = '0; lt_a = '0; lt_d = '0;
    cmd_valid = 1'b0; cmd_theta1 = '0; cmd_theta2 = '0; cmd_theta3 = '0; cmd_theta4 = '0;
    res_ready = 1'b0;
    core_if.OUT_VALID = 1'b0; core_if.OUT_X = '0; core_if.OUT_Y = '0; core_if.OUT_Z = '0;
    clear_model();
    test_reset();
    test_link_phase();
    test_result_hold();
    test_timeout();
    test_back_to_back();
    test_write_while_busy();
    test_spurious();
    test_rst_mid_link();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dh_host_driver.md
# dh_host_driver

Synthesizable initiator for the DH forward-kinematics core's input protocol. It holds a 4-entry link-parameter table written by a host, and for each pose command drives the DH link phase and joint phase onto the core's input ports. It then waits for the core's single-cycle result, with a timeout, and returns the X/Y/Z result to the host through a valid/ready handshake. It sits between the on-chip host/register logic and the DH core, replacing the bench-only stimulus generator in system builds.

## Interface
Parameters:
- TIMEOUT, 1000, maximum number of WAIT cycles before a pose is aborted with a timeout result.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- lt_we  in  1  link-table write strobe; honoured only when busy=0.
- lt_addr  in  2  link index, 0..3 (link 1..4).
- lt_alpha  in  6  signed link twist.
- lt_a  in  3  unsigned link length.
- lt_d  in  3  unsigned link offset.
- cmd_valid  in  1  pose request.
- cmd_ready  out  1  high only in IDLE.
- cmd_theta1..cmd_theta4  in  6 each  signed joint angles.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts result.
- res_x, res_y, res_z  out  9 each  signed result.
- res_timeout  out  1  result produced by timeout; X/Y/Z are 0.
- busy  out  1  high in every state except IDLE.
- err_spurious  out  1  sticky flag: OUT_VALID seen outside WAIT.
- IN_VALID_1, IN_VALID_2  out  1 each  to the DH core.
- ALPHA_I  out  6, A_I  out  3, D_I  out  3  to the DH core.
- THETA_JOINT_1..THETA_JOINT_4  out  6 each  to the DH core.
- OUT_VALID  in  1, OUT_X/OUT_Y/OUT_Z  in  9 each  from the DH core.

## Operation
States:
- IDLE → LINK on cmd accept (cmd_valid & cmd_ready). The thetas are latched at accept.
- LINK: 4 cycles. Link index k=0..3 drives the table entry k on ALPHA_I/A_I/D_I with IN_VALID_1=1. Then → GAP.
- GAP: 1 cycle, all core inputs 0. Then → THETA.
- THETA: 1 cycle. IN_VALID_2=1 and the latched thetas are on THETA_JOINT_1..4. Then → WAIT with the timeout counter cleared.
- WAIT:
  - If OUT_VALID=1: capture OUT_X/Y/Z, set res_timeout=0, → RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and OUT_VALID=0: X/Y/Z=0, res_timeout=1, → RESP.
  - If OUT_VALID arrives in the same cycle the counter hits its limit, the data wins (res_timeout=0).
- RESP: res_valid=1 and held stable until res_ready. The handshake cycle → IDLE.

Rules:
- All core inputs are registered and are 0 whenever their valid is low.
- The full link table is resent on every pose.
- Link-table writes while busy=1 are dropped. A write in the same cycle as a cmd accept does take effect, but the command uses the pre-write table only if the entry is read before the write; the write lands first, since LINK starts next cycle.
- OUT_VALID in any state other than WAIT sets err_spurious and is otherwise ignored. err_spurious is cleared only by rst.
- Reset value of every output and table entry is 0, and state is IDLE. rst mid-transaction drops the pose immediately: IN_VALID_1/2 are low the next cycle and no result is produced.
- Counter width is $clog2(TIMEOUT+1).

## Timing
- Accept at cycle 0.
- IN_VALID_1 high cycles 1–4 (links 1..4).
- Cycle 5 is the gap.
- IN_VALID_2 high cycle 6.
- WAIT begins cycle 7.
- OUT_VALID sampled at cycle N → res_valid at N+1.
- Timeout result at cycle 7+TIMEOUT.
- Earliest next accept is the cycle after the res handshake.
- Minimum command period is 9 cycles plus core latency.

## Structure
- Package dh_pkg holds:
  - width constants: ANG_W=6, LEN_W=3, POS_W=9, NUM_LINKS=4;
  - the state enum (IDLE, LINK, GAP, THETA, WAIT, RESP);
  - the dh_link_t struct {alpha, a, d}.
- Sub-module dh_link_table: a 4×dh_link_t register file with one synchronous write port and one combinational read port, cleared on rst.
- The top contains the FSM, link index, timeout counter and result registers.

## Test plan
- Write links (alpha,a,d) = (5,1,2),(−3,7,0),(31,4,4),(−32,0,7) → cmd thetas (1,−1,10,−20) → IN_VALID_1 cycles 1–4 carry exactly those values in order, cycle 5 is all 0, cycle 6 carries IN_VALID_2 with the thetas.
- Core model returns OUT_VALID at cycle 20 with X/Y/Z=(100,−256,255) → res_valid at cycle 21 with those values and res_timeout=0. Hold res_ready=0 for 5 cycles: values stay stable and cmd_ready=0.
- TIMEOUT=16, core never responds → res_valid at cycle 23, res_timeout=1, X/Y/Z=0. A next command is accepted after the handshake.
- OUT_VALID pulsed during IDLE and during LINK → err_spurious=1, no res_valid, and the flag persists until rst.
- lt_we to link 2 during WAIT → table unchanged; the next pose resends the old link-2 values.
- rst asserted at cycle 3 of LINK → IN_VALID_1=0 from the next cycle, all outputs 0, table cleared, cmd_ready=1 after reset release.
